// File: rtl/aes_encrypt_core.sv
// Iterative AES encryption core (128/192/256-bit keys): one key word or one cipher round per cycle.
// Optional macro AES_OUT_MASK_EN forces out_data to zero whenever out_valid is low.
module aes_encrypt_core #(
   parameter int KEY_BITS = 128
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         key_load,
   input  logic [255:0] key_in,
   output logic         key_ready,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int NK    = KEY_BITS / 32;
   localparam int NR    = NK + 6;
   localparam int NW    = 4 * (NR + 1);
   localparam int IDX_W = $clog2(NW + 1);
   localparam int RW    = $clog2(NR + 1);

   localparam logic [IDX_W-1:0] NK_IDX   = IDX_W'(NK);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);
   localparam logic [RW-1:0]    NR_CNT   = RW'(NR);
   localparam logic [2:0]       MOD_LAST = 3'(NK - 1);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [2:0] {IDLE, KEY_EXP, READY, ROUND, HOLD} state_e;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] idx;
      idx = {~b, 3'b111};
      return SBOX[idx -: 8];
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   state_e             state_q, state_d;
   logic [127:0]       aesState_q, aesState_d;
   logic [RW-1:0]      roundCnt_q, roundCnt_d;
   logic [IDX_W-1:0]   keyIdx_q, keyIdx_d;
   logic [2:0]         modCnt_q, modCnt_d;
   logic [7:0]         rcon_q, rcon_d;
   logic               loadKey, expandWrite;
   logic [31:0]        schedWord [NW];
   logic [31:0]        prevWord, oldWord, expTemp, newWord;
   logic [IDX_W-1:0]   rkBase;
   logic [127:0]       roundKey, roundKey0, subBytes, shiftRows, mixCols, roundOut;

   // Each schedule word is its own register; i mod 8 keeps the key slice in range for every word.
   for (genvar j = 0; j < NW; j++) begin : g_sched
      logic [31:0] word_q;
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            word_q <= '0;
         end else if (loadKey && (j < NK)) begin
            word_q <= key_in[255 - 32*(j % 8) -: 32];
         end else if (expandWrite && (keyIdx_q == IDX_W'(j))) begin
            word_q <= newWord;
         end
      end
      assign schedWord[j] = word_q;
   end

   assign prevWord = schedWord[keyIdx_q - IDX_W'(1)];
   assign oldWord  = schedWord[keyIdx_q - NK_IDX];
   assign newWord  = oldWord ^ expTemp;

   always_comb begin
      expTemp = prevWord;
      if (modCnt_q == 3'd0) begin
         expTemp = subWord({prevWord[23:0], prevWord[31:24]}) ^ {rcon_q, 24'h0};
      end else if ((NK == 8) && (modCnt_q == 3'd4)) begin
         expTemp = subWord(prevWord);
      end
   end

   for (genvar k = 0; k < 16; k++) begin : g_sub
      assign subBytes[127 - 8*k -: 8] = sbox(aesState_q[127 - 8*k -: 8]);
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign shiftRows[127 - 8*(4*c + r) -: 8] = subBytes[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
      assign a0 = shiftRows[127 - 32*c -: 8];
      assign a1 = shiftRows[119 - 32*c -: 8];
      assign a2 = shiftRows[111 - 32*c -: 8];
      assign a3 = shiftRows[103 - 32*c -: 8];
      assign mixCols[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                          a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                          a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                          xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   end

   assign rkBase    = IDX_W'({roundCnt_q, 2'b00});
   assign roundKey  = {schedWord[rkBase], schedWord[rkBase + IDX_W'(1)],
                       schedWord[rkBase + IDX_W'(2)], schedWord[rkBase + IDX_W'(3)]};
   assign roundKey0 = {schedWord[0], schedWord[1], schedWord[2], schedWord[3]};
   assign roundOut  = ((roundCnt_q == NR_CNT) ? shiftRows : mixCols) ^ roundKey;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         aesState_q <= '0;
         roundCnt_q <= '0;
         keyIdx_q   <= '0;
         modCnt_q   <= '0;
         rcon_q     <= '0;
      end else begin
         state_q    <= state_d;
         aesState_q <= aesState_d;
         roundCnt_q <= roundCnt_d;
         keyIdx_q   <= keyIdx_d;
         modCnt_q   <= modCnt_d;
         rcon_q     <= rcon_d;
      end
   end

   // key_load is only honoured in IDLE/READY and takes priority over a plaintext transfer.
   always_comb begin
      state_d     = state_q;
      aesState_d  = aesState_q;
      roundCnt_d  = roundCnt_q;
      keyIdx_d    = keyIdx_q;
      modCnt_d    = modCnt_q;
      rcon_d      = rcon_q;
      loadKey     = 1'b0;
      expandWrite = 1'b0;
      case (state_q)
         IDLE, READY: begin
            if (key_load) begin
               loadKey  = 1'b1;
               keyIdx_d = NK_IDX;
               modCnt_d = 3'd0;
               rcon_d   = 8'h01;
               state_d  = KEY_EXP;
            end else if ((state_q == READY) && in_valid) begin
               aesState_d = in_data ^ roundKey0;
               roundCnt_d = RW'(1);
               state_d    = ROUND;
            end
         end
         KEY_EXP: begin
            expandWrite = 1'b1;
            keyIdx_d    = keyIdx_q + IDX_W'(1);
            modCnt_d    = (modCnt_q == MOD_LAST) ? 3'd0 : modCnt_q + 3'd1;
            if (modCnt_q == 3'd0) begin
               rcon_d = xtime(rcon_q);
            end
            if (keyIdx_q == LAST_IDX) begin
               state_d = READY;
            end
         end
         ROUND: begin
            aesState_d = roundOut;
            if (roundCnt_q == NR_CNT) begin
               state_d = HOLD;
            end else begin
               roundCnt_d = roundCnt_q + RW'(1);
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = READY;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == READY);
   assign out_valid = (state_q == HOLD);
   assign key_ready = (state_q == READY) || (state_q == ROUND) || (state_q == HOLD);
   assign busy      = (state_q == KEY_EXP) || (state_q == ROUND) || (state_q == HOLD);

`ifdef AES_OUT_MASK_EN
   assign out_data = out_valid ? aesState_q : '0;
`else
   assign out_data = aesState_q;
`endif

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed bench for aes_encrypt_core: three instances (128/192/256-bit keys) share one stimulus,
// since the left-aligned 256-bit key 00..1f also carries the 128- and 192-bit FIPS-197 keys.
module tb_aes_encrypt_core;

   localparam logic [255:0] KEY    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] ROUND0 = 128'h00102030405060708090a0b0c0d0e0f0;
   localparam logic [127:0] ROUND1 = 128'h89d810e8855ace682d1843d8cb128fe4;

   logic         clk = 1'b0;
   logic         resetN;
   logic         keyLoad;
   logic [255:0] keyIn;
   logic         inValid;
   logic [127:0] inData;
   logic         outReady;
   logic         keyReady [3];
   logic         inReady  [3];
   logic         outValid [3];
   logic         busyOut  [3];
   logic [127:0] outData  [3];

   int checks = 0;
   int passes = 0;

   int           expKeyCycles [3] = '{40, 46, 52};
   int           expLatency   [3] = '{10, 12, 14};
   logic [127:0] expCt        [3] = '{CT128, CT192, CT256};

   always #5 clk = ~clk;

   for (genvar d = 0; d < 3; d++) begin : g_dut
      aes_encrypt_core #(.KEY_BITS(128 + 64*d)) dut (
         .clk       (clk),
         .reset_n   (resetN),
         .key_load  (keyLoad),
         .key_in    (keyIn),
         .key_ready (keyReady[d]),
         .in_valid  (inValid),
         .in_ready  (inReady[d]),
         .in_data   (inData),
         .out_valid (outValid[d]),
         .out_ready (outReady),
         .out_data  (outData[d]),
         .busy      (busyOut[d])
      );
   end

   // Drives one block into the 128-bit instance and releases it once out_valid appears.
   task automatic encryptBlock(output int latency, output logic [127:0] ct);
      inValid = 1'b1;
      inData  = PT;
      @(negedge clk);
      inValid = 1'b0;
      latency = 0;
      while (!outValid[0] && latency < 40) begin
         @(negedge clk);
         latency++;
      end
      ct = outData[0];
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
   endtask

   task automatic waitKeyReady(output int cycles);
      cycles = 0;
      while (!keyReady[0] && cycles < 80) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset;
      resetN = 1'b0; keyLoad = 1'b0; keyIn = KEY; inValid = 1'b0; inData = PT; outReady = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({keyReady[d], inReady[d], outValid[d], busyOut[d]} !== 4'b0000)
            $display("[TB] FAIL reset_flags dut%0d: got %b expected 0000", d,
                     {keyReady[d], inReady[d], outValid[d], busyOut[d]});
         else passes++;
         checks++;
         if (outData[d] !== 128'h0)
            $display("[TB] FAIL reset_out_data dut%0d: got %h expected 0", d, outData[d]);
         else passes++;
      end
      resetN  = 1'b1;
      inValid = 1'b1;
      repeat (3) @(negedge clk);
      inValid = 1'b0;
      checks++;
      if ({inReady[0], busyOut[0], outValid[0]} !== 3'b000)
         $display("[TB] FAIL no_key_accept: got in_ready/busy/out_valid %b expected 000",
                  {inReady[0], busyOut[0], outValid[0]});
      else passes++;
   endtask

   task automatic test_key_expansion;
      int readyAt [3] = '{0, 0, 0};
      keyLoad = 1'b1;
      @(negedge clk);
      keyLoad = 1'b0;
      checks++;
      if ({busyOut[0], keyReady[0], inReady[0]} !== 3'b100)
         $display("[TB] FAIL key_exp_entry: got busy/key_ready/in_ready %b expected 100",
                  {busyOut[0], keyReady[0], inReady[0]});
      else passes++;
      for (int cyc = 1; cyc <= 70; cyc++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++)
            if (keyReady[d] && readyAt[d] == 0) readyAt[d] = cyc;
      end
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (readyAt[d] !== expKeyCycles[d])
            $display("[TB] FAIL key_ready_latency dut%0d: got %0d expected %0d", d, readyAt[d], expKeyCycles[d]);
         else passes++;
         checks++;
         if ({busyOut[d], inReady[d]} !== 2'b01)
            $display("[TB] FAIL ready_state dut%0d: got busy/in_ready %b expected 01", d, {busyOut[d], inReady[d]});
         else passes++;
      end
   endtask

   task automatic test_multi_key;
      int           validAt [3] = '{0, 0, 0};
      logic [127:0] ctSeen  [3];
      logic [127:0] expR0, expR1;
`ifdef AES_OUT_MASK_EN
      expR0 = 128'h0;
      expR1 = 128'h0;
`else
      expR0 = ROUND0;
      expR1 = ROUND1;
`endif
      for (int d = 0; d < 3; d++) ctSeen[d] = 128'h0;
      inValid = 1'b1;
      inData  = PT;
      @(negedge clk);
      inValid = 1'b0;
      checks++;
      if (outData[0] !== expR0)
         $display("[TB] FAIL round0_state: got %h expected %h", outData[0], expR0);
      else passes++;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            checks++;
            if (outData[0] !== expR1)
               $display("[TB] FAIL round1_state: got %h expected %h", outData[0], expR1);
            else passes++;
         end
         for (int d = 0; d < 3; d++)
            if (outValid[d] && validAt[d] == 0) begin
               validAt[d] = cyc;
               ctSeen[d]  = outData[d];
            end
      end
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (validAt[d] !== expLatency[d])
            $display("[TB] FAIL out_valid_latency dut%0d: got %0d expected %0d", d, validAt[d], expLatency[d]);
         else passes++;
         checks++;
         if (ctSeen[d] !== expCt[d])
            $display("[TB] FAIL ciphertext dut%0d: got %h expected %h", d, ctSeen[d], expCt[d]);
         else passes++;
      end
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({outValid[d], inReady[d]} !== 2'b01)
            $display("[TB] FAIL release dut%0d: got out_valid/in_ready %b expected 01", d, {outValid[d], inReady[d]});
         else passes++;
      end
   endtask

   task automatic test_hold;
      int           cyc = 0;
      int           unstable = 0;
      int           lat;
      logic [127:0] held, ct;
      inValid = 1'b1;
      inData  = PT;
      @(negedge clk);
      inValid = 1'b0;
      while (!outValid[0] && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      held = outData[0];
      checks++;
      if (!outValid[0] || held !== CT128)
         $display("[TB] FAIL hold_entry: got valid=%b data=%h expected valid=1 data=%h", outValid[0], held, CT128);
      else passes++;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin keyLoad = 1'b1; keyIn = '1; end
         if (i == 6) begin keyLoad = 1'b0; keyIn = KEY; end
         @(negedge clk);
         if (outData[0] !== held || !outValid[0] || inReady[0]) unstable++;
      end
      checks++;
      if (unstable != 0)
         $display("[TB] FAIL hold_stable: got %0d disturbed cycles expected 0", unstable);
      else passes++;
      checks++;
      if ({keyReady[0], busyOut[0]} !== 2'b11)
         $display("[TB] FAIL hold_key_ignored: got key_ready/busy %b expected 11", {keyReady[0], busyOut[0]});
      else passes++;
      outReady = 1'b1;
      checks++;
      if (inReady[0] !== 1'b0)
         $display("[TB] FAIL handshake_in_ready: got %b expected 0", inReady[0]);
      else passes++;
      @(negedge clk);
      outReady = 1'b0;
      checks++;
      if ({outValid[0], inReady[0]} !== 2'b01)
         $display("[TB] FAIL after_handshake: got out_valid/in_ready %b expected 01", {outValid[0], inReady[0]});
      else passes++;
      encryptBlock(lat, ct);
      checks++;
      if (ct !== CT128 || lat != 10)
         $display("[TB] FAIL post_hold_block: got %h lat %0d expected %h lat 10", ct, lat, CT128);
      else passes++;
   endtask

   task automatic test_key_load_wins;
      int           cyc, lat;
      logic [127:0] ct;
      keyLoad = 1'b1;
      inValid = 1'b1;
      inData  = PT;
      @(negedge clk);
      keyLoad = 1'b0;
      inValid = 1'b0;
      checks++;
      if ({busyOut[0], keyReady[0], inReady[0], outValid[0]} !== 4'b1000)
         $display("[TB] FAIL key_load_priority: got busy/key_ready/in_ready/out_valid %b expected 1000",
                  {busyOut[0], keyReady[0], inReady[0], outValid[0]});
      else passes++;
      waitKeyReady(cyc);
      checks++;
      if (cyc != 40)
         $display("[TB] FAIL rekey_latency: got %0d expected 40", cyc);
      else passes++;
      encryptBlock(lat, ct);
      checks++;
      if (ct !== CT128 || lat != 10)
         $display("[TB] FAIL rekey_block: got %h lat %0d expected %h lat 10", ct, lat, CT128);
      else passes++;
   endtask

   task automatic test_back_to_back;
      int firstPulse = -1;
      int secondPulse = -1;
      int pulses = 0;
      int badData = 0;
      inValid  = 1'b1;
      inData   = PT;
      outReady = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         if (outValid[0]) begin
            pulses++;
            if (outData[0] !== CT128) badData++;
            if (firstPulse < 0) firstPulse = cyc;
            else if (secondPulse < 0) secondPulse = cyc;
         end
      end
      inValid = 1'b0;
      repeat (16) @(negedge clk);
      outReady = 1'b0;
      checks++;
      if (firstPulse != 10)
         $display("[TB] FAIL b2b_first_latency: got %0d expected 10", firstPulse);
      else passes++;
      checks++;
      if (secondPulse - firstPulse != 12)
         $display("[TB] FAIL b2b_spacing: got %0d expected 12", secondPulse - firstPulse);
      else passes++;
      checks++;
      if (pulses != 2 || badData != 0)
         $display("[TB] FAIL b2b_pulses: got %0d pulses %0d bad expected 2 pulses 0 bad", pulses, badData);
      else passes++;
      checks++;
      if (inReady[0] !== 1'b1)
         $display("[TB] FAIL b2b_drain: got in_ready %b expected 1", inReady[0]);
      else passes++;
   endtask

   task automatic test_reset_mid_round;
      int           cyc, lat;
      int           leaks = 0;
      logic [127:0] ct;
      inValid = 1'b1;
      inData  = PT;
      @(negedge clk);
      inValid = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if ({busyOut[0], outValid[0]} !== 2'b10)
         $display("[TB] FAIL mid_round_busy: got busy/out_valid %b expected 10", {busyOut[0], outValid[0]});
      else passes++;
      #2 resetN = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({keyReady[d], inReady[d], outValid[d], busyOut[d]} !== 4'b0000 || outData[d] !== 128'h0)
            $display("[TB] FAIL async_reset dut%0d: got flags %b data %h expected 0000 and 0", d,
                     {keyReady[d], inReady[d], outValid[d], busyOut[d]}, outData[d]);
         else passes++;
      end
      @(negedge clk);
      resetN  = 1'b1;
      inValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (inReady[0] || busyOut[0] || outValid[0] || keyReady[0]) leaks++;
      end
      inValid = 1'b0;
      checks++;
      if (leaks != 0)
         $display("[TB] FAIL post_reset_idle: got %0d active cycles expected 0", leaks);
      else passes++;
      keyLoad = 1'b1;
      @(negedge clk);
      keyLoad = 1'b0;
      waitKeyReady(cyc);
      checks++;
      if (cyc != 40)
         $display("[TB] FAIL reload_latency: got %0d expected 40", cyc);
      else passes++;
      encryptBlock(lat, ct);
      checks++;
      if (ct !== CT128 || lat != 10)
         $display("[TB] FAIL reload_block: got %h lat %0d expected %h lat 10", ct, lat, CT128);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_key_expansion();
      test_multi_key();
      test_hold();
      test_key_load_wins();
      test_back_to_back();
      test_reset_mid_round();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time limit reached before summary");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
